// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared definitions for the router packet transmit path.
//               Transmit state encoding, header field positions (shared
//               with the router receive side), invalid destination code and
//               the maximum payload length fixed by the 6-bit length field.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  // Largest payload the 6-bit header length field can describe.
  localparam logic [5:0] MAX_LEN = 6'd63;

  // Destination code with no router output port behind it.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: {length[5:0], address[1:0]}.
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  // Transmit state machine encoding.
  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_HEADER  = 3'd1,
    TX_PAYLOAD = 3'd2,
    TX_PARITY  = 3'd3,
    TX_GAP     = 3'd4
  } tx_state_e;

  // Assemble a header byte from its length and address fields.
  function automatic logic [7:0] make_header(input logic [5:0] len,
                                             input logic [1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : router_tx_buf
// Description : 64x8 payload store for the packet transmitter. Writes land
//               at the current fill count, which doubles as the write
//               pointer. The read port is synchronous: o_rd_data holds the
//               byte addressed by i_rd_addr on the previous edge, so the
//               caller presents the *next* read address combinationally.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               i_wr, i_wr_data  - qualified write strobe and data
//               i_clr            - empty the buffer (count back to 0)
//               i_rd_addr        - read address for the next edge
//               o_rd_data        - registered read data
//               o_count          - bytes currently buffered
//               o_count_nxt      - value o_count takes on the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module router_tx_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr,
  input  logic [7:0] i_wr_data,
  input  logic       i_clr,
  input  logic [5:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic [5:0] o_count,
  output logic [5:0] o_count_nxt
);

  logic [7:0] r_mem [0:63];
  logic [7:0] r_rd_data;
  logic [5:0] r_count;
  logic [5:0] w_count_nxt;

  // Clear wins over a write; the caller never asserts both together.
  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_wr) begin
      w_count_nxt = r_count + 6'd1;
    end
  end

  // Storage is not reset: contents are meaningless once count is cleared.
  always_ff @(posedge clk) begin
    if (i_wr) begin
      r_mem[r_count] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;

endmodule : router_tx_buf
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Router packet transmitter. Buffers up to 63 payload bytes,
//               then sends header, payload and parity on the router input
//               byte stream, honouring busy backpressure, followed by IFG
//               idle cycles before the next packet may start.
// Parameters  : IFG          - idle cycles after the parity byte (>= 1)
// Ports       : clk, reset   - clock, synchronous active-high reset
//               wr_en/wr_data/wr_ready - payload byte write interface
//               dest_addr, start, err_inject - launch request and options
//               busy         - router backpressure, holds the current byte
//               datain, packet_valid - registered byte stream to router
//               tx_active, done, reject - status
//               byte_count   - payload bytes currently buffered
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
  parameter int IFG = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [1:0] dest_addr,
  input  logic       start,
  input  logic       err_inject,
  input  logic       busy,
  output logic [7:0] datain,
  output logic       packet_valid,
  output logic       tx_active,
  output logic       done,
  output logic       reject,
  output logic [5:0] byte_count
);

  import router_pkg::*;

  localparam int                 c_GAP_W    = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(IFG - 1);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  tx_state_e          r_state;
  logic [5:0]         r_len;
  logic [5:0]         r_idx;
  logic               r_inv;
  logic [7:0]         r_acc;
  logic [c_GAP_W-1:0] r_gap;
  logic [7:0]         r_datain;
  logic               r_pv;
  logic               r_active;
  logic               r_done;
  logic               r_reject;
  logic               r_wr_ready;

  tx_state_e          w_state_nxt;
  logic [5:0]         w_len_nxt;
  logic [5:0]         w_idx_nxt;
  logic               w_inv_nxt;
  logic [7:0]         w_acc_nxt;
  logic [c_GAP_W-1:0] w_gap_nxt;
  logic [7:0]         w_data_nxt;
  logic               w_pv_nxt;
  logic               w_active_nxt;
  logic               w_done_nxt;
  logic               w_reject_nxt;
  logic               w_wr_ready_nxt;

  logic               w_wr;
  logic               w_buf_clr;
  logic [7:0]         w_rd_data;
  logic [5:0]         w_count;
  logic [5:0]         w_count_nxt;
  logic [7:0]         w_acc_in;
  logic               w_start_ok;

  // r_wr_ready already folds in IDLE, not-done and not-full.
  assign w_wr = wr_en && r_wr_ready;

  // Accumulator value including the byte currently on datain; it is only
  // committed on an edge where that byte is accepted.
  assign w_acc_in = r_acc ^ r_datain;

  assign w_start_ok = (w_count != '0) && (dest_addr != ADDR_INVALID);

  // --------------------------------------------------------------------------
  // Payload buffer. Its read address is the *next* payload index so that the
  // byte needed on the following accept edge is already in w_rd_data.
  // --------------------------------------------------------------------------
  router_tx_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_wr        (w_wr),
    .i_wr_data   (wr_data),
    .i_clr       (w_buf_clr),
    .i_rd_addr   (w_idx_nxt),
    .o_rd_data   (w_rd_data),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt)
  );

  // --------------------------------------------------------------------------
  // Next-state logic. r_idx is the buffer read pointer: while PAYLOAD shows
  // byte k, r_idx = k+1, so r_idx == r_len marks the last payload byte.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_inv_nxt    = r_inv;
    w_acc_nxt    = r_acc;
    w_gap_nxt    = r_gap;
    w_data_nxt   = r_datain;
    w_pv_nxt     = r_pv;
    w_active_nxt = r_active;
    w_done_nxt   = 1'b0;
    w_reject_nxt = 1'b0;
    w_buf_clr    = 1'b0;

    case (r_state)
      TX_IDLE: begin
        // The done cycle is treated as not yet idle for launch requests.
        if (start && !r_done) begin
          if (w_start_ok) begin
            // The destination is captured directly into the header byte,
            // which stays on datain until the router accepts it.
            w_state_nxt  = TX_HEADER;
            w_len_nxt    = w_count;
            w_inv_nxt    = err_inject;
            w_acc_nxt    = '0;
            w_idx_nxt    = '0;
            w_data_nxt   = make_header(w_count, dest_addr);
            w_pv_nxt     = 1'b1;
            w_active_nxt = 1'b1;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end

      TX_HEADER: begin
        if (!busy) begin
          // Length is never zero here, so payload always follows.
          w_acc_nxt   = w_acc_in;
          w_data_nxt  = w_rd_data;
          w_idx_nxt   = r_idx + 6'd1;
          w_state_nxt = TX_PAYLOAD;
        end
      end

      TX_PAYLOAD: begin
        if (!busy) begin
          w_acc_nxt = w_acc_in;
          if (r_idx == r_len) begin
            w_state_nxt = TX_PARITY;
            w_data_nxt  = r_inv ? ~w_acc_in : w_acc_in;
            w_pv_nxt    = 1'b0;
          end else begin
            w_data_nxt = w_rd_data;
            w_idx_nxt  = r_idx + 6'd1;
          end
        end
      end

      TX_PARITY: begin
        if (!busy) begin
          w_state_nxt = TX_GAP;
          w_data_nxt  = '0;
          w_gap_nxt   = '0;
        end
      end

      TX_GAP: begin
        // Nothing is offered to the router here, so busy is irrelevant.
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt  = TX_IDLE;
          w_done_nxt   = 1'b1;
          w_active_nxt = 1'b0;
          w_idx_nxt    = '0;
          w_inv_nxt    = 1'b0;
          w_buf_clr    = 1'b1;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      default: begin
        w_state_nxt  = TX_IDLE;
        w_data_nxt   = '0;
        w_pv_nxt     = 1'b0;
        w_active_nxt = 1'b0;
        w_idx_nxt    = '0;
      end
    endcase

    // Registered so that wr_ready reflects exactly when a write is taken.
    w_wr_ready_nxt = (w_state_nxt == TX_IDLE) && !w_done_nxt &&
                     (w_count_nxt < MAX_LEN);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= TX_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_inv      <= 1'b0;
      r_acc      <= '0;
      r_gap      <= '0;
      r_datain   <= '0;
      r_pv       <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_reject   <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_inv      <= w_inv_nxt;
      r_acc      <= w_acc_nxt;
      r_gap      <= w_gap_nxt;
      r_datain   <= w_data_nxt;
      r_pv       <= w_pv_nxt;
      r_active   <= w_active_nxt;
      r_done     <= w_done_nxt;
      r_reject   <= w_reject_nxt;
      r_wr_ready <= w_wr_ready_nxt;
    end
  end

  assign datain       = r_datain;
  assign packet_valid = r_pv;
  assign tx_active    = r_active;
  assign done         = r_done;
  assign reject       = r_reject;
  assign wr_ready     = r_wr_ready;
  assign byte_count   = w_count;

endmodule : router_pkt_tx
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Directed self-checking bench for router_pkt_tx: reset state,
//               basic packet, busy hold, reject cases, full buffer, parity
//               error injection and mid-packet reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [1:0] dest_addr;
  logic       start;
  logic       err_inject;
  logic       busy;
  logic [7:0] datain;
  logic       packet_valid;
  logic       tx_active;
  logic       done;
  logic       reject;
  logic [5:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Bytes accepted by the "router" during the last run_packet call.
  logic [7:0] cap_data [0:127];
  logic       cap_pv   [0:127];
  int         cap_n;
  int         cap_done;
  int         cap_hold;

  always #5 clk = ~clk;

  router_pkt_tx #(.IFG(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .dest_addr    (dest_addr),
    .start        (start),
    .err_inject   (err_inject),
    .busy         (busy),
    .datain       (datain),
    .packet_valid (packet_valid),
    .tx_active    (tx_active),
    .done         (done),
    .reject       (reject),
    .byte_count   (byte_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    cycle();
    wr_en   = 1'b0;
  endtask

  // Launch a packet and act as the router: records every accepted byte,
  // optionally raising busy while payload byte busy_idx is presented.
  // cap_done is the number of edges from the start edge to done (-1 = none).
  task automatic run_packet(input logic [1:0] addr, input logic inv,
                            input int busy_idx, input int busy_cycles);
    int cyc;
    int left;
    bit seen_par;
    dest_addr  = addr;
    err_inject = inv;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
    err_inject = 1'b0;
    dest_addr  = 2'd0;
    cyc      = 0;
    left     = busy_cycles;
    cap_n    = 0;
    cap_done = -1;
    cap_hold = 0;
    seen_par = 1'b0;
    while (cyc < 400) begin
      if (done) begin
        cap_done = cyc;
        break;
      end
      busy = 1'b0;
      if (packet_valid && cap_n == busy_idx + 1) begin
        cap_hold++;
        if (left > 0) begin
          busy = 1'b1;
          left--;
        end
      end
      if (!busy && (packet_valid || (!seen_par && cap_n > 0 && tx_active))) begin
        if (cap_n < 128) begin
          cap_data[cap_n] = datain;
          cap_pv[cap_n]   = packet_valid;
        end
        if (!packet_valid) seen_par = 1'b1;
        cap_n++;
      end
      cycle();
      cyc++;
    end
    busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_tests++;
    if ({datain, packet_valid, tx_active, done, reject} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h pv=%b act=%b done=%b rej=%b, want all 0",
               datain, packet_valid, tx_active, done, reject);
    end
    n_tests++;
    if (byte_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", byte_count);
    end
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [0:4];
    logic       exp_v [0:4];
    exp_d = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    n_tests++;
    if (byte_count !== 6'd3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 3", byte_count);
    end
    run_packet(2'd1, 1'b0, -1, 0);
    n_tests++;
    if (cap_n !== 5) begin
      n_fail++;
      $display("FAIL basic_len: got %0d bytes want 5", cap_n);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_d[i] || cap_pv[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got %h/pv=%b want %h/pv=%b",
                 i, cap_data[i], cap_pv[i], exp_d[i], exp_v[i]);
      end
    end
    n_tests++;
    if (cap_done !== 7) begin
      n_fail++;
      $display("FAIL basic_done_time: got %0d want 7", cap_done);
    end
    n_tests++;
    if (byte_count !== 6'd0) begin
      n_fail++;
      $display("FAIL basic_count_clear: got %0d want 0", byte_count);
    end
    cycle();
    n_tests++;
    if (done !== 1'b0 || tx_active !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after_done: got done=%b act=%b rdy=%b want 0/0/1",
               done, tx_active, wr_ready);
    end
  endtask

  task automatic test_busy();
    logic [7:0] exp_d [0:4];
    exp_d = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    run_packet(2'd1, 1'b0, 1, 3);
    n_tests++;
    if (cap_hold !== 4) begin
      n_fail++;
      $display("FAIL busy_hold: 0x22 shown %0d cycles want 4", cap_hold);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL busy_byte%0d: got %h want %h", i, cap_data[i], exp_d[i]);
      end
    end
    n_tests++;
    if (cap_done !== 10) begin
      n_fail++;
      $display("FAIL busy_done_time: got %0d want 10", cap_done);
    end
    cycle();
  endtask

  task automatic test_reject();
    logic [7:0] exp_d [0:3];
    exp_d = '{8'h0A, 8'hA5, 8'h5A, 8'hF5};
    // Empty buffer.
    dest_addr = 2'd1;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
    n_tests++;
    if (reject !== 1'b1 || packet_valid !== 1'b0 || tx_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_empty: got rej=%b pv=%b act=%b want 1/0/0",
               reject, packet_valid, tx_active);
    end
    cycle();
    n_tests++;
    if (reject !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: got %b want 0", reject);
    end
    // Invalid destination with data buffered.
    write_byte(8'hA5);
    write_byte(8'h5A);
    dest_addr = 2'd3;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
    n_tests++;
    if (reject !== 1'b1 || packet_valid !== 1'b0 || byte_count !== 6'd2) begin
      n_fail++;
      $display("FAIL reject_addr3: got rej=%b pv=%b cnt=%0d want 1/0/2",
               reject, packet_valid, byte_count);
    end
    cycle();
    // Retained buffer still sends correctly.
    run_packet(2'd2, 1'b0, -1, 0);
    n_tests++;
    if (cap_n !== 4 || cap_done !== 6) begin
      n_fail++;
      $display("FAIL reject_resend_len: got n=%0d done_at=%0d want 4/6", cap_n, cap_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL reject_resend_byte%0d: got %h want %h", i, cap_data[i], exp_d[i]);
      end
    end
    cycle();
  endtask

  task automatic test_full();
    logic [7:0] p;
    logic [7:0] v;
    for (int i = 0; i < 63; i++) begin
      if (i == 62) begin
        n_tests++;
        if (wr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_ready62: got %b want 1", wr_ready);
        end
      end
      v = 8'(i * 7 + 3);
      write_byte(v);
    end
    n_tests++;
    if (byte_count !== 6'd63 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_at63: got cnt=%0d rdy=%b want 63/0", byte_count, wr_ready);
    end
    write_byte(8'hEE);
    n_tests++;
    if (byte_count !== 6'd63) begin
      n_fail++;
      $display("FAIL full_drop64: got cnt=%0d want 63", byte_count);
    end
    run_packet(2'd0, 1'b0, -1, 0);
    n_tests++;
    if (cap_n !== 65 || cap_done !== 67) begin
      n_fail++;
      $display("FAIL full_len: got n=%0d done_at=%0d want 65/67", cap_n, cap_done);
    end
    n_tests++;
    if (cap_data[0] !== 8'hFC) begin
      n_fail++;
      $display("FAIL full_header: got %h want fc", cap_data[0]);
    end
    p = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      v = 8'(i * 7 + 3);
      p = p ^ v;
      n_tests++;
      if (cap_data[i+1] !== v || cap_pv[i+1] !== 1'b1) begin
        n_fail++;
        $display("FAIL full_payload%0d: got %h/pv=%b want %h/pv=1",
                 i, cap_data[i+1], cap_pv[i+1], v);
      end
    end
    n_tests++;
    if (cap_data[64] !== p || cap_pv[64] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_parity: got %h/pv=%b want %h/pv=0", cap_data[64], cap_pv[64], p);
    end
    cycle();
  endtask

  task automatic test_err_inject();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    run_packet(2'd1, 1'b1, -1, 0);
    n_tests++;
    if (cap_n !== 5 || cap_data[4] !== 8'hF2 || cap_pv[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_parity: got n=%0d %h/pv=%b want 5 f2/pv=0",
               cap_n, cap_data[4], cap_pv[4]);
    end
    cycle();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    run_packet(2'd1, 1'b0, -1, 0);
    n_tests++;
    if (cap_n !== 5 || cap_data[4] !== 8'h0D) begin
      n_fail++;
      $display("FAIL err_next_parity: got n=%0d %h want 5 0d", cap_n, cap_data[4]);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d [0:3];
    exp_d = '{8'h09, 8'h44, 8'h55, 8'h18};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    dest_addr = 2'd1;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
    cycle();
    cycle();
    n_tests++;
    if (packet_valid !== 1'b1 || datain !== 8'h22) begin
      n_fail++;
      $display("FAIL rstmid_in_payload: got %h/pv=%b want 22/pv=1", datain, packet_valid);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_tests++;
    if (datain !== 8'h00 || packet_valid !== 1'b0 || byte_count !== 6'd0 ||
        tx_active !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_state: got d=%h pv=%b cnt=%0d act=%b rdy=%b want 00/0/0/0/1",
               datain, packet_valid, byte_count, tx_active, wr_ready);
    end
    write_byte(8'h44);
    write_byte(8'h55);
    run_packet(2'd1, 1'b0, -1, 0);
    n_tests++;
    if (cap_n !== 4 || cap_done !== 6) begin
      n_fail++;
      $display("FAIL rstmid_resend_len: got n=%0d done_at=%0d want 4/6", cap_n, cap_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cap_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL rstmid_byte%0d: got %h want %h", i, cap_data[i], exp_d[i]);
      end
    end
    cycle();
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    dest_addr  = 2'd0;
    start      = 1'b0;
    err_inject = 1'b0;
    busy       = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_reject();
    test_full();
    test_err_inject();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_router_pkt_tx
`default_nettype wire
